// File: rtl/channel_pkg.sv
// Shared types and helpers for the channel LLR generator: fix5p10 samples,
// FSM state encoding and symmetric LLR saturation.
package channel_pkg;

  localparam int FIX5P10_ONE = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef logic signed [14:0] fix5p10_t;

  // One queued bit pair waiting for its noise sample.
  typedef struct packed {
    logic       last;
    logic [1:0] bits;
  } bitq_t;

  // Clamp to +/-(2^(llr_w-1)-1) so the most negative code never appears.
  function automatic logic signed [15:0] sat_llr(input logic signed [15:0] v,
                                                 input int llr_w);
    logic signed [15:0] lim;
    lim = 16'((1 << (llr_w - 1)) - 1);
    if (v > lim)       return lim;
    else if (v < -lim) return -lim;
    else               return v;
  endfunction

endpackage

// File: rtl/channel_llr_fifo.sv
// Synchronous FIFO for LLR pairs; DEPTH must be a power of two.
module channel_llr_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is still taken when a pop frees the slot.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/channel_llr_gen.sv
// BPSK-maps encoder bit pairs, adds AWGN noise and quantizes to LLRs, with
// credit flow control since the noise source cannot stall. HARD_ERR_CNT_EN adds err_cnt_o.
module channel_llr_gen
  import channel_pkg::*;
#(
  parameter int N          = 648,
  parameter int LLR_W      = 8,
  parameter int SHIFT      = 7,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   bit_valid_i,
  output logic                   bit_ready_o,
  input  logic [1:0]             bit_data_i,
  output logic                   awgn_enable_o,
  output logic                   awgn_pop_o,
  input  logic                   awgn_valid_i,
  input  fix5p10_t               noise0_i,
  input  fix5p10_t               noise1_i,
  output logic                   llr_valid_o,
  input  logic                   llr_ready_i,
  output logic [2*LLR_W-1:0]     llr_data_o,
  output logic                   llr_last_o,
  output logic                   busy_o
`ifdef HARD_ERR_CNT_EN
  ,
  output logic [$clog2(N+1)-1:0] err_cnt_o
`endif
);
  localparam int NP  = N / 2;
  localparam int PCW = $clog2(NP + 1);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int CRW = FCW + 2;
  localparam int FW  = 2 * LLR_W + 1;
  localparam logic signed [15:0] S_ONE = 16'(FIX5P10_ONE);

  function automatic logic signed [LLR_W-1:0] to_llr(input logic b, input fix5p10_t n);
    logic signed [15:0] y, q;
    y = b ? -S_ONE : S_ONE;
    y = y + 16'(n);
    if (y > 16'sd16383)       y = 16'sd16383;
    else if (y < -16'sd16383) y = -16'sd16383;
    q = y >>> SHIFT;
    q = sat_llr(q, LLR_W);
    return q[LLR_W-1:0];
  endfunction

  state_e               state_q, state_d;
  logic [PCW-1:0]       pair_cnt_q;
  bitq_t                bq_q [4];
  bitq_t                bq_head;
  logic [1:0]           bq_wr_q, bq_rd_q;
  logic [2:0]           bq_cnt_q;
  logic                 samp_vld_q, samp_last_q;
  logic [2*LLR_W-1:0]   samp_q;
  logic                 err_q;
  logic                 hs, q_empty, q_pop, start_acc;
  logic                 fifo_pop, fifo_empty, fifo_full;
  logic [FCW-1:0]       fifo_cnt;
  logic [FW-1:0]        fifo_dout;
  logic [CRW-1:0]       credit;
  logic signed [LLR_W-1:0] llr0, llr1;

  // Credit covers every pair that will eventually need a FIFO slot.
  assign credit      = CRW'(bq_cnt_q) + CRW'(samp_vld_q) + CRW'(fifo_cnt);
  assign bit_ready_o = (state_q == RUN) && (credit < CRW'(FIFO_DEPTH))
                       && (pair_cnt_q < PCW'(NP));
  assign hs            = bit_valid_i && bit_ready_o;
  assign awgn_pop_o    = hs;
  assign awgn_enable_o = hs;
  assign busy_o        = (state_q != IDLE);
  assign start_acc     = (state_q == IDLE) && start_i;

  assign q_empty = (bq_cnt_q == '0);
  assign q_pop   = awgn_valid_i && !q_empty;
  assign bq_head = bq_q[bq_rd_q];
  assign llr0    = to_llr(bq_head.bits[0], noise0_i);
  assign llr1    = to_llr(bq_head.bits[1], noise1_i);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (hs && pair_cnt_q == PCW'(NP - 1)) state_d = DRAIN;
      DRAIN:   if (q_empty && !samp_vld_q && fifo_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      pair_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc)   pair_cnt_q <= '0;
      else if (hs)     pair_cnt_q <= pair_cnt_q + PCW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 4; i++) bq_q[i] <= '0;
      bq_wr_q  <= '0;
      bq_rd_q  <= '0;
      bq_cnt_q <= '0;
    end else begin
      if (hs) begin
        bq_q[bq_wr_q] <= '{last: (pair_cnt_q == PCW'(NP - 1)), bits: bit_data_i};
        bq_wr_q       <= bq_wr_q + 2'd1;
      end
      if (q_pop) bq_rd_q <= bq_rd_q + 2'd1;
      bq_cnt_q <= bq_cnt_q + 3'(hs) - 3'(q_pop);
    end
  end

  // Noise with no matching bit pair is dropped and latched as a protocol error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      samp_vld_q  <= 1'b0;
      samp_last_q <= 1'b0;
      samp_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      samp_vld_q <= q_pop;
      if (q_pop) begin
        samp_q      <= {llr1, llr0};
        samp_last_q <= bq_head.last;
      end
      err_q <= err_q | (awgn_valid_i && q_empty) | (samp_vld_q && fifo_full && !fifo_pop);
    end
  end

  assign fifo_pop = llr_ready_i && !fifo_empty;

  channel_llr_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (samp_vld_q),
    .pop_i   (fifo_pop),
    .data_i  ({samp_last_q, samp_q}),
    .data_o  (fifo_dout),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_cnt)
  );

  assign llr_valid_o = !fifo_empty;
  assign llr_data_o  = fifo_empty ? '0 : fifo_dout[2*LLR_W-1:0];
  assign llr_last_o  = !fifo_empty && fifo_dout[FW-1];

`ifdef HARD_ERR_CNT_EN
  localparam int ECW = $clog2(N + 1);
  logic [ECW-1:0] err_cnt_q;
  logic [1:0]     miss;

  // Hard decision is the LLR sign bit; compare against the transmitted bit.
  assign miss = {llr1[LLR_W-1] ^ bq_head.bits[1], llr0[LLR_W-1] ^ bq_head.bits[0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        err_cnt_q <= '0;
    else if (start_acc) err_cnt_q <= '0;
    else if (q_pop)     err_cnt_q <= err_cnt_q + ECW'(miss[0]) + ECW'(miss[1]);
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_channel_llr_gen.sv
// Directed-vector bench for channel_llr_gen with a 3-cycle noise source model.
module tb_channel_llr_gen;
  import channel_pkg::*;

  localparam int N = 24, LLR_W = 8, SHIFT = 7, DEPTH = 8, NP = N / 2;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, bit_valid = 1'b0, llr_ready = 1'b0;
  logic [1:0] bit_data = 2'b00;
  logic bit_ready, awgn_enable, awgn_pop, awgn_valid, llr_valid, llr_last, busy;
  fix5p10_t noise0, noise1, nz0 = '0, nz1 = '0;
  logic [2*LLR_W-1:0] llr_data;
`ifdef HARD_ERR_CNT_EN
  logic [$clog2(N+1)-1:0] err_cnt;
`endif

  channel_llr_gen #(.N(N), .LLR_W(LLR_W), .SHIFT(SHIFT), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .bit_valid_i(bit_valid), .bit_ready_o(bit_ready), .bit_data_i(bit_data),
    .awgn_enable_o(awgn_enable), .awgn_pop_o(awgn_pop), .awgn_valid_i(awgn_valid),
    .noise0_i(noise0), .noise1_i(noise1),
    .llr_valid_o(llr_valid), .llr_ready_i(llr_ready), .llr_data_o(llr_data),
    .llr_last_o(llr_last), .busy_o(busy)
`ifdef HARD_ERR_CNT_EN
    , .err_cnt_o(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Noise source: each request is answered exactly 3 cycles later.
  logic [2:0]       np_v;
  logic [2:0][14:0] np_n0, np_n1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) np_v <= '0;
    else begin
      np_v  <= {np_v[1:0], awgn_enable};
      np_n0 <= {np_n0[1:0], nz0};
      np_n1 <= {np_n1[1:0], nz1};
    end
  end
  assign awgn_valid = np_v[2];
  assign noise0     = np_n0[2];
  assign noise1     = np_n1[2];

  typedef struct {logic [2*LLR_W-1:0] d; logic last; int cyc;} obs_t;
  obs_t got_q[$];
  int   hs_cyc_q[$];
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    obs_t o;
    if (rst_n) begin
      if (bit_valid && bit_ready) hs_cyc_q.push_back(cyc);
      if (llr_valid && llr_ready) begin
        o.d = llr_data; o.last = llr_last; o.cyc = cyc;
        got_q.push_back(o);
      end
    end
  end

  typedef struct {logic [1:0] b; int n0; int n1; int e0; int e1;} vec_t;
  vec_t fa[NP], fb[NP], fc[NP], cur[NP];
  int total = 0, bad = 0;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int lane(input logic [2*LLR_W-1:0] d, input int k);
    logic signed [LLR_W-1:0] v;
    v = d[k*LLR_W +: LLR_W];
    return int'(v);
  endfunction

  task automatic reset_checks(input string p);
    check({p, "_bit_ready"}, bit_ready, 0);
    check({p, "_awgn_pop"}, awgn_pop, 0);
    check({p, "_awgn_enable"}, awgn_enable, 0);
    check({p, "_llr_valid"}, llr_valid, 0);
    check({p, "_llr_data"}, int'(llr_data), 0);
    check({p, "_llr_last"}, llr_last, 0);
    check({p, "_busy"}, busy, 0);
  endtask

  task automatic send_pair(input int i, input bit st);
    int t = 0;
    bit_valid = 1'b1; bit_data = cur[i].b; start = st;
    nz0 = 15'(cur[i].n0); nz1 = 15'(cur[i].n1);
    @(negedge clk);
    while (!bit_ready) begin
      if (++t > 300) begin
        check($sformatf("bit_ready_timeout[%0d]", i), bit_ready, 1);
        break;
      end
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
    end
    if (bit_ready) check($sformatf("awgn_pop[%0d]", i), awgn_pop, 1);
    @(posedge clk); #1;
    bit_valid = 1'b0; start = 1'b0;
  endtask

  task automatic send_frame(input int restart_at);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < NP; i++) send_pair(i, i == restart_at);
  endtask

  task automatic collect_frame(input int base, input string tag);
    int t = 0;
    while ((got_q.size() < base + NP || busy) && t < 400) begin
      @(negedge clk); t++;
    end
    check({tag, "_count"}, got_q.size() - base, NP);
    check({tag, "_busy"}, busy, 0);
    for (int i = 0; i < NP && base + i < got_q.size(); i++) begin
      check($sformatf("%s_lane0[%0d]", tag, i), lane(got_q[base+i].d, 0), cur[i].e0);
      check($sformatf("%s_lane1[%0d]", tag, i), lane(got_q[base+i].d, 1), cur[i].e1);
      check($sformatf("%s_last[%0d]", tag, i), int'(got_q[base+i].last), (i == NP - 1) ? 1 : 0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t pat[4];
    int base, hb;
    // bits 0,1,1,0,0,0,1,1 with zero noise; bit_data = {later, earlier}
    pat[0] = '{2'b10, 0, 0, 8, -8};
    pat[1] = '{2'b01, 0, 0, -8, 8};
    pat[2] = '{2'b00, 0, 0, 8, 8};
    pat[3] = '{2'b11, 0, 0, -8, -8};
    for (int i = 0; i < NP; i++) fa[i] = pat[i % 4];
    fb[0]  = pat[0];
    fb[1]  = pat[1];
    fb[2]  = pat[2];
    fb[3]  = pat[3];
    fb[4]  = '{2'b10,  16383, -16384,  127, -127};
    fb[5]  = '{2'b10,  -2048,   2048,   -8,    8};
    fb[6]  = '{2'b00,    100,  -1025,    8,   -1};
    fb[7]  = '{2'b10,  -1024,   1023,    0,   -1};
    fb[8]  = '{2'b10,  15000, -15000,  125, -126};
    fb[9]  = '{2'b01,  16383, -16384,  119, -120};
    fb[10] = '{2'b01, -16384,  16383, -127,  127};
    fb[11] = pat[0];
    for (int i = 0; i < NP; i++) fc[i] = '{2'b00, -2048, 128 * i, -8, 8 + i};

    repeat (3) @(negedge clk);
    reset_checks("rst");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Zero-noise frame: values, llr_last placement, 5-cycle latency
    llr_ready = 1'b1;
    for (int i = 0; i < NP; i++) cur[i] = fa[i];
    base = got_q.size(); hb = hs_cyc_q.size();
    send_frame(-1);
    collect_frame(base, "zero");
    if (got_q.size() > base && hs_cyc_q.size() > hb)
      check("latency", got_q[base].cyc - hs_cyc_q[hb], 5);
`ifdef HARD_ERR_CNT_EN
    check("zero_err_cnt", int'(err_cnt), 0);
`endif

    // Rounding/saturation vectors, with a start pulse mid-frame that must be ignored
    @(posedge clk); #1;
    for (int i = 0; i < NP; i++) cur[i] = fb[i];
    base = got_q.size();
    send_frame(5);
    collect_frame(base, "sat");
    repeat (10) @(negedge clk);
    check("restart_no_extra", got_q.size() - base, NP);
    check("restart_idle", busy, 0);
`ifdef HARD_ERR_CNT_EN
    check("sat_err_cnt", int'(err_cnt), 5);
`endif

    // Back-pressure: decoder stalls for 40 cycles
    @(posedge clk); #1 llr_ready = 1'b0;
    for (int i = 0; i < NP; i++) cur[i] = fc[i];
    base = got_q.size(); hb = hs_cyc_q.size();
    fork
      send_frame(-1);
      begin
        repeat (20) @(negedge clk);
        check("bp_outstanding", hs_cyc_q.size() - hb, DEPTH);
        check("bp_bit_ready", bit_ready, 0);
        check("bp_llr_valid", llr_valid, 1);
        repeat (20) @(negedge clk);
        check("bp_outstanding_hold", hs_cyc_q.size() - hb, DEPTH);
        check("bp_hold_lane0", lane(llr_data, 0), -8);
        check("bp_hold_lane1", lane(llr_data, 1), 8);
        @(posedge clk); #1 llr_ready = 1'b1;
      end
    join
    collect_frame(base, "bp");
`ifdef HARD_ERR_CNT_EN
    check("bp_err_cnt", int'(err_cnt), 12);
`endif

    // Reset with three pairs in flight aborts the frame
    @(posedge clk); #1;
    for (int i = 0; i < NP; i++) cur[i] = fa[i];
    base = got_q.size();
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 3; i++) send_pair(i, 1'b0);
    rst_n = 1'b0;
    #1 reset_checks("abort");
    repeat (2) @(posedge clk); #1 rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("abort_no_output", got_q.size() - base, 0);
    check("abort_idle", busy, 0);

    @(posedge clk); #1;
    base = got_q.size();
    send_frame(-1);
    collect_frame(base, "post_rst");
`ifdef HARD_ERR_CNT_EN
    check("post_rst_err_cnt", int'(err_cnt), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/channel_llr_gen.md
# channel_llr_gen

Downstream consumer of the AWGN noise generator. Takes encoded codeword bits two at a time, requests one noise pair per bit pair, BPSK-maps the bits (0 → +1.0, 1 → −1.0), adds the fix5p10 noise, and quantizes the channel sample into signed LLRs. The LLRs are streamed with frame delimiting into the min-sum LDPC decoder input. Back-pressure is handled with a credit scheme, because the noise generator itself cannot stall.

## Interface
Parameters:
- N, 648: codeword length in bits; must be even.
- LLR_W, 8: LLR width, signed two's complement.
- SHIFT, 7: right shift applied to the fix5p10 sum before saturation.
- FIFO_DEPTH, 8: output FIFO depth in LLR pairs; power of two, ≥ 4.

Ports:
- clk, in, 1: single clock.
- rst, in, 1: asynchronous, active-low reset.
- start, in, 1: single-cycle frame-start pulse; ignored unless in IDLE.
- bit_valid, in, 1: encoder bit pair valid.
- bit_ready, out, 1: block accepts a bit pair.
- bit_data, in, 2: [0] is the earlier bit (pairs with noise0); [1] pairs with noise1.
- awgn_enable, out, 1: driven identically to awgn_pop.
- awgn_pop, out, 1: requests one noise pair; high exactly on bit handshake cycles.
- awgn_valid, in, 1: noise pair valid; arrives exactly 3 cycles after the matching awgn_enable.
- noise0, in, 15: signed fix5p10 noise sample.
- noise1, in, 15: signed fix5p10 noise sample.
- llr_valid, out, 1: output LLR pair valid.
- llr_ready, in, 1: decoder accepts the output pair.
- llr_data, out, 2·LLR_W: [LLR_W-1:0] is the LLR for bit_data[0].
- llr_last, out, 1: marks the final pair of the frame.
- busy, out, 1: high in any state other than IDLE.

## Operation
State machine: IDLE → RUN on `start`. RUN → DRAIN when N/2 pairs have been accepted. DRAIN → IDLE when the bit queue, the sample register and the output FIFO are all empty and the last pair has handshaken.

Bit handshake:
- bit_ready = (state==RUN) && (credit < FIFO_DEPTH) && (pair_cnt < N/2).
- credit = number of issued-but-unreturned pops + pairs in the sample register + FIFO occupancy.
- A bit handshake pushes bit_data into a 4-entry bit queue, pulses awgn_pop/awgn_enable, and increments pair_cnt.

Sample path:
- On awgn_valid, pop the bit queue and pair the bits with noise0/noise1.
- Mapping: s = +1024 for bit 0, −1024 for bit 1.
- Sum: y = s + n in 16-bit signed, saturated to 15-bit signed (±16383).
- LLR = y >>> SHIFT (arithmetic shift), saturated symmetrically to ±(2^(LLR_W−1)−1). Code −2^(LLR_W−1) is never produced.
- Result is registered, then written into the output FIFO.

Output:
- The FIFO drives llr_valid/llr_data/llr_last.
- llr_last is stored alongside the pair whose input index is N/2−1.

Error cases:
- awgn_valid with an empty bit queue: protocol error. The sample is dropped and the sticky internal flag err_q is set; err_q is cleared only by reset.
- Simultaneous push and pop on the queue or FIFO are both honored; occupancy is unchanged.

## Timing
- Reset values: bit_ready 0, awgn_pop 0, awgn_enable 0, llr_valid 0, llr_data 0, llr_last 0, busy 0. All counters, queues and the FIFO are emptied and the state is IDLE.
- `start` is registered; bit_ready can first assert the cycle after start.
- Latency from bit handshake to llr_valid is 5 cycles when the FIFO is empty: 3 cycles noise, 1 cycle sample register, 1 cycle FIFO write/read.
- Throughput is one pair per cycle while llr_ready=1.
- llr_valid/llr_data are held stable while llr_ready=0.
- Credit bound: FIFO never overflows with llr_ready held low indefinitely; at most FIFO_DEPTH pairs are outstanding.
- Reset mid-frame aborts the frame immediately; no llr_last is emitted.

## Configuration
- HARD_ERR_CNT_EN defined: adds output port err_cnt, width $clog2(N+1).
  - Counts bits whose hard decision (LLR sign, with LLR<0 read as 1 and 0 read as 0) differs from the transmitted bit.
  - Cleared on `start`; final value valid from the cycle llr_last handshakes until the next `start`.
- HARD_ERR_CNT_EN undefined: no port and no counter logic.

## Structure
- Shared package channel_pkg holds:
  - FIX5P10_ONE = 1024
  - the state enum {IDLE, RUN, DRAIN}
  - the fix5p10 typedef (logic signed [14:0])
  - the LLR saturation function
- One sub-module: channel_llr_fifo. Synchronous FIFO with parameters width and depth; exposes push/pop/empty/full/count.

## Test plan
- Zero noise, N=8, bits 0,1,1,0,0,0,1,1, llr_ready=1 → LLR sequence +8,−8,−8,+8,+8,+8,−8,−8; llr_last on the 4th pair; first llr_valid 5 cycles after the first bit handshake.
- Saturation: noise0=+16383 with bit 0, noise1=−16384 with bit 1 → llr_data {−127,+127}, never −128.
- Back-pressure: llr_ready=0 for 40 cycles mid-frame → bit_ready drops after 8 outstanding pairs, no pair is lost or duplicated, order is preserved.
- Reset asserted in RUN with 3 pairs outstanding → all outputs return to reset values; a new `start` runs a full clean frame.
- `start` pulsed during RUN → ignored; the frame completes with exactly N/2 pairs.
- With HARD_ERR_CNT_EN: noise forced to −2048 on every bit-0 position → err_cnt = number of 0 bits in the frame.
